// File: rtl/tdm_demux4.sv
// tdm_demux4: four-slot TDM receive demultiplexer.
// Steers an interleaved sample stream into four registered channels.
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] ch0_data,
  output logic [WIDTH-1:0] ch1_data,
  output logic [WIDTH-1:0] ch2_data,
  output logic [WIDTH-1:0] ch3_data,
  output logic [3:0]       ch_valid,
  output logic             frame_done,
  output logic             sync_err,
  output logic             locked
);

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]       state_q;
  logic [0:0]       state_d;
  logic [1:0]       slot_q;
  logic [1:0]       slot_d;
  logic [3:0]       cap;
  logic             done_d;
  logic             err_d;
  logic [WIDTH-1:0] ch_q [4];
  logic [3:0]       valid_q;
  logic             done_q;
  logic             err_q;

  logic hunt_sync;
  logic lock_first;
  logic lock_miss;
  logic lock_next;
  logic lock_early;
  logic slot0;

  assign slot0 = (slot_q == 2'd0);

  assign hunt_sync  = din_valid && (state_q == HUNT) && frame_sync;
  assign lock_first = din_valid && (state_q == LOCK) && slot0 && frame_sync;
  assign lock_miss  = din_valid && (state_q == LOCK) && slot0 && !frame_sync;
  assign lock_next  = din_valid && (state_q == LOCK) && !slot0 && !frame_sync;
  assign lock_early = din_valid && (state_q == LOCK) && !slot0 && frame_sync;

  // Decode the per-sample action: which channel captures, next slot/state.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cap     = 4'b0000;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (1'b1)
      hunt_sync: begin
        cap     = 4'b0001;
        slot_d  = 2'd1;
        state_d = LOCK;
      end
      lock_first: begin
        cap    = 4'b0001;
        slot_d = 2'd1;
      end
      lock_miss: begin
        err_d   = 1'b1;
        slot_d  = 2'd0;
        state_d = HUNT;
      end
      lock_next: begin
        cap    = 4'b0001 << slot_q;
        slot_d = slot_q + 2'd1;
        done_d = (slot_q == 2'd3);
      end
      lock_early: begin
        err_d  = 1'b1;
        cap    = 4'b0001;
        slot_d = 2'd1;
      end
      default: begin
      end
    endcase
  end

  // Alignment state and slot pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      slot_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  // Channel registers: only the addressed channel loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 4; n++) begin
        ch_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (cap[n]) begin
          ch_q[n] <= din;
        end
      end
    end
  end

  // Registered strobes and pulses, aligned with the data update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 4'b0000;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= cap;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ch0_data   = ch_q[0];
  assign ch1_data   = ch_q[1];
  assign ch2_data   = ch_q[2];
  assign ch3_data   = ch_q[3];
  assign ch_valid   = valid_q;
  assign frame_done = done_q;
  assign sync_err   = err_q;
  assign locked     = (state_q == LOCK);

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed bench for tdm_demux4.
// Each scenario task drives samples and checks outputs inline.
module tb_tdm_demux4;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       frame_sync;
  logic [7:0] ch0_data;
  logic [7:0] ch1_data;
  logic [7:0] ch2_data;
  logic [7:0] ch3_data;
  logic [3:0] ch_valid;
  logic       frame_done;
  logic       sync_err;
  logic       locked;

  int tests;
  int fails;

  logic [7:0] chd [4];
  assign chd[0] = ch0_data;
  assign chd[1] = ch1_data;
  assign chd[2] = ch2_data;
  assign chd[3] = ch3_data;

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .ch0_data   (ch0_data),
    .ch1_data   (ch1_data),
    .ch2_data   (ch2_data),
    .ch3_data   (ch3_data),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one sample at a negedge, return at the next negedge.
  task automatic send(input logic v, input logic s, input logic [7:0] d);
    din_valid  = v;
    frame_sync = s;
    din        = d;
    @(posedge clk);
    @(negedge clk);
    din_valid  = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    din = 8'h00; din_valid = 1'b0; frame_sync = 1'b0; rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({ch0_data, ch1_data, ch2_data, ch3_data} !== 32'h0) begin
      fails++;
      $display("FAIL reset_data got %h exp 0",
               {ch0_data, ch1_data, ch2_data, ch3_data});
    end
    tests++;
    if ({ch_valid, frame_done, sync_err, locked} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl got %b exp 0",
               {ch_valid, frame_done, sync_err, locked});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    logic [7:0] a [4];
    a[0] = 8'hA0; a[1] = 8'hA1; a[2] = 8'hA2; a[3] = 8'hA3;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, (i == 0), a[i]);
      tests++;
      if (ch_valid !== (4'b0001 << i)) begin
        fails++;
        $display("FAIL lock_valid%0d got %b exp %b", i, ch_valid, 4'b0001 << i);
      end
      tests++;
      if (chd[i] !== a[i]) begin
        fails++;
        $display("FAIL lock_data%0d got %h exp %h", i, chd[i], a[i]);
      end
      tests++;
      if (frame_done !== (i == 3) || sync_err !== 1'b0 || locked !== 1'b1) begin
        fails++;
        $display("FAIL lock_flags%0d got fd=%b se=%b lk=%b exp fd=%b se=0 lk=1",
                 i, frame_done, sync_err, locked, (i == 3));
      end
    end
    send(1'b0, 1'b0, 8'hFF);
    tests++;
    if (ch_valid !== 4'b0 || frame_done !== 1'b0 || ch3_data !== 8'hA3) begin
      fails++;
      $display("FAIL lock_idle got v=%b fd=%b d3=%h exp v=0 fd=0 d3=a3",
               ch_valid, frame_done, ch3_data);
    end
  endtask

  task automatic test_hunt_discard();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      send(1'b1, 1'b0, 8'(i));
      tests++;
      if (ch_valid !== 4'b0 || locked !== 1'b0 || sync_err !== 1'b0
          || ch0_data !== 8'h00) begin
        fails++;
        $display("FAIL hunt_drop%0d got v=%b lk=%b se=%b d0=%h exp all 0",
                 i, ch_valid, locked, sync_err, ch0_data);
      end
    end
    send(1'b1, 1'b1, 8'h11);
    tests++;
    if (ch0_data !== 8'h11 || locked !== 1'b1 || ch_valid !== 4'b0001) begin
      fails++;
      $display("FAIL hunt_sync got d0=%h lk=%b v=%b exp d0=11 lk=1 v=0001",
               ch0_data, locked, ch_valid);
    end
  endtask

  task automatic test_gapped();
    do_reset();
    send(1'b1, 1'b1, 8'h10);
    send(1'b0, 1'b0, 8'hEE);
    tests++;
    if (ch_valid !== 4'b0 || frame_done !== 1'b0 || sync_err !== 1'b0
        || locked !== 1'b1) begin
      fails++;
      $display("FAIL gap_idle got v=%b fd=%b se=%b lk=%b exp 0,0,0,1",
               ch_valid, frame_done, sync_err, locked);
    end
    send(1'b1, 1'b0, 8'h20);
    tests++;
    if (ch_valid !== 4'b0010 || ch1_data !== 8'h20) begin
      fails++;
      $display("FAIL gap_ch1 got v=%b d1=%h exp 0010 20", ch_valid, ch1_data);
    end
    send(1'b0, 1'b1, 8'hEE);
    send(1'b0, 1'b0, 8'hEE);
    tests++;
    if (ch_valid !== 4'b0 || sync_err !== 1'b0) begin
      fails++;
      $display("FAIL gap_idle2 got v=%b se=%b exp 0 0", ch_valid, sync_err);
    end
    send(1'b1, 1'b0, 8'h30);
    tests++;
    if (ch_valid !== 4'b0100 || ch2_data !== 8'h30 || frame_done !== 1'b0) begin
      fails++;
      $display("FAIL gap_ch2 got v=%b d2=%h fd=%b exp 0100 30 0",
               ch_valid, ch2_data, frame_done);
    end
    send(1'b1, 1'b0, 8'h40);
    tests++;
    if (ch_valid !== 4'b1000 || ch3_data !== 8'h40 || frame_done !== 1'b1
        || ch0_data !== 8'h10) begin
      fails++;
      $display("FAIL gap_ch3 got v=%b d3=%h fd=%b d0=%h exp 1000 40 1 10",
               ch_valid, ch3_data, frame_done, ch0_data);
    end
  endtask

  task automatic test_early_sync();
    send(1'b1, 1'b1, 8'h10);
    send(1'b1, 1'b0, 8'h20);
    send(1'b1, 1'b1, 8'h55);
    tests++;
    if (sync_err !== 1'b1 || ch0_data !== 8'h55 || ch_valid !== 4'b0001
        || frame_done !== 1'b0 || locked !== 1'b1) begin
      fails++;
      $display("FAIL early_err got se=%b d0=%h v=%b fd=%b lk=%b exp 1 55 0001 0 1",
               sync_err, ch0_data, ch_valid, frame_done, locked);
    end
    tests++;
    if (ch1_data !== 8'h20) begin
      fails++;
      $display("FAIL early_keep got d1=%h exp 20", ch1_data);
    end
    send(1'b1, 1'b0, 8'h66);
    tests++;
    if (ch1_data !== 8'h66 || ch_valid !== 4'b0010 || sync_err !== 1'b0) begin
      fails++;
      $display("FAIL early_next got d1=%h v=%b se=%b exp 66 0010 0",
               ch1_data, ch_valid, sync_err);
    end
  endtask

  task automatic test_missing_sync();
    send(1'b1, 1'b0, 8'h21);
    send(1'b1, 1'b0, 8'h22);
    tests++;
    if (frame_done !== 1'b1 || ch3_data !== 8'h22) begin
      fails++;
      $display("FAIL miss_frame got fd=%b d3=%h exp 1 22", frame_done, ch3_data);
    end
    send(1'b1, 1'b0, 8'h77);
    tests++;
    if (sync_err !== 1'b1 || ch_valid !== 4'b0 || locked !== 1'b0
        || ch0_data !== 8'h55 || frame_done !== 1'b0) begin
      fails++;
      $display("FAIL miss_err got se=%b v=%b lk=%b d0=%h fd=%b exp 1 0 0 55 0",
               sync_err, ch_valid, locked, ch0_data, frame_done);
    end
    send(1'b1, 1'b1, 8'h88);
    tests++;
    if (locked !== 1'b1 || ch0_data !== 8'h88 || sync_err !== 1'b0) begin
      fails++;
      $display("FAIL miss_relock got lk=%b d0=%h se=%b exp 1 88 0",
               locked, ch0_data, sync_err);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    send(1'b1, 1'b1, 8'h01);
    send(1'b1, 1'b0, 8'h02);
    send(1'b1, 1'b0, 8'h03);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({ch0_data, ch1_data, ch2_data, ch3_data} !== 32'h0
        || {ch_valid, frame_done, sync_err, locked} !== 7'b0) begin
      fails++;
      $display("FAIL midrst_async got d=%h c=%b exp 0 0",
               {ch0_data, ch1_data, ch2_data, ch3_data},
               {ch_valid, frame_done, sync_err, locked});
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b1, 1'b0, 8'h99);
    tests++;
    if (ch_valid !== 4'b0 || ch0_data !== 8'h00 || locked !== 1'b0
        || sync_err !== 1'b0) begin
      fails++;
      $display("FAIL midrst_drop got v=%b d0=%h lk=%b se=%b exp 0 0 0 0",
               ch_valid, ch0_data, locked, sync_err);
    end
    send(1'b1, 1'b1, 8'h5A);
    tests++;
    if (ch0_data !== 8'h5A || ch_valid !== 4'b0001 || locked !== 1'b1) begin
      fails++;
      $display("FAIL midrst_relock got d0=%h v=%b lk=%b exp 5a 0001 1",
               ch0_data, ch_valid, locked);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_lock();
    test_hunt_discard();
    test_gapped();
    test_early_sync();
    test_missing_sync();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer: the receive-side counterpart to the 4-to-1 data selector. It accepts one WIDTH-bit sample per valid cycle from a slot-interleaved stream (slot 0,1,2,3 repeating, slot 0 flagged by `frame_sync`). It steers each sample into one of four registered channel outputs with a per-channel strobe. It tracks frame alignment with a two-state FSM and reports sync errors. It sits downstream of a TDM serializer built around the 4-to-1 selector.

## Interface
- `WIDTH`, default 8, sample width in bits (legal 1..32)
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  reset; one clock; reset is asynchronous and active-low
- `din`  input  WIDTH  incoming sample
- `din_valid`  input  1  `din` and `frame_sync` are meaningful this cycle
- `frame_sync`  input  1  current sample is slot 0; ignored when `din_valid`=0
- `ch0_data`..`ch3_data`  output  WIDTH each  last sample captured for slot 0..3
- `ch_valid`  output  4  one-cycle strobe; bit n = `chn_data` updated this cycle
- `frame_done`  output  1  one-cycle pulse: slot 3 of an aligned frame captured
- `sync_err`  output  1  one-cycle pulse: framing violation detected
- `locked`  output  1  FSM is in LOCK

## Operation
- State: FSM {HUNT, LOCK}, 2-bit slot counter `slot` (next expected slot), four WIDTH-bit channel registers.
- Cycles with `din_valid`=0: no state change, all strobes/pulses low, data registers hold.
- HUNT, `din_valid`=1, `frame_sync`=0: sample discarded, no strobe, stay HUNT.
- HUNT, `din_valid`=1, `frame_sync`=1: `ch0_data`<=`din`, `ch_valid`=0001, `slot`<=1, go LOCK.
- LOCK, `din_valid`=1, `slot`=0, `frame_sync`=1: capture to ch0, `slot`<=1.
- LOCK, `din_valid`=1, `slot`=0, `frame_sync`=0 (missing sync): `sync_err` pulse, sample discarded, no strobe, go HUNT, `slot`<=0.
- LOCK, `din_valid`=1, `slot`!=0, `frame_sync`=0: capture to ch[`slot`], `ch_valid` bit `slot` set, `slot`<=`slot`+1 (mod 4; 3 wraps to 0). Capture at `slot`=3 also pulses `frame_done`.
- LOCK, `din_valid`=1, `slot`!=0, `frame_sync`=1 (early sync, short frame): `sync_err` pulse, resync. Sample captured to ch0, `ch_valid`=0001, `slot`<=1, stay LOCK, no `frame_done`.
- Only one `ch_valid` bit is ever set per cycle. `frame_done` and `sync_err` are never high in the same cycle.
- Non-captured channel registers always hold. Partial frames are not cleared on error.
- `locked` = (state == LOCK).

## Timing
- All outputs are registered. Sample presented at edge k appears on `chn_data` together with its `ch_valid` bit after edge k, i.e. 1-cycle latency.
- `frame_done` coincides with `ch_valid`[3] and `ch3_data` update.
- `sync_err` is asserted in the cycle after the offending sample's edge.
- `locked` rises in the cycle after the first synced sample. It falls in the cycle after a missing-sync sample.
- Back-to-back valid samples are accepted every cycle. Gaps in `din_valid` may occur anywhere in a frame with no effect on alignment.
- Reset (asserted at any time, including mid-frame): state HUNT, `slot`=0, `ch0_data`..`ch3_data`=0, `ch_valid`=0, `frame_done`=0, `sync_err`=0, `locked`=0 immediately, without waiting for a clock. First capture after deassertion requires a `frame_sync` sample.

## Test plan
- Reset then lock: WIDTH=8. After reset, check all outputs are 0. Drive A0(sync),A1,A2,A3 on consecutive cycles -> `ch_valid` 0001,0010,0100,1000. Data = A0..A3. `frame_done` pulses with 1000. `locked`=1 from the cycle after A0.
- Hunt discard: send 3 samples with `frame_sync`=0, then 11(sync) -> no strobes for the first three. `ch0_data`=11 and `locked`=1 one cycle after the sync sample.
- Gapped stream: frame 10(sync),_,20,_,_,30,40 where _ means `din_valid`=0 -> captures unaffected by gaps. No pulses in gap cycles. `frame_done` with 40.
- Early sync: after 10(sync),20, drive 55(sync) -> `sync_err` pulse, `ch0_data`=55, `ch_valid`=0001, no `frame_done`. A following 66 lands in ch1.
- Missing sync: complete frame, then 77 with `frame_sync`=0 -> `sync_err`, no strobe, `locked`=0, `ch0_data` unchanged. Next sync sample relocks.
- Mid-frame reset: pulse `rst_n` low asynchronously after slot 2 capture -> all outputs 0 immediately. After release, a non-sync sample is ignored.
